// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program counter with return stack.
//   - default widths/depth for pc_stack
//   - pc_op_e: the single operation selected on a given edge
//   - pc_decode(): collapses the command strobes into one op by fixed priority
//     (Ret > Call > Ld > Br > Up > hold; Clr is handled by the registers).
package pc_pkg;

  localparam int PC_W     = 7;
  localparam int PC_DEPTH = 4;
  localparam int PC_OFFW  = 5;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BR,
    OP_LD,
    OP_CALL,
    OP_RET
  } pc_op_e;

  function automatic pc_op_e pc_decode(input logic ret, input logic call,
                                       input logic ld, input logic br,
                                       input logic up);
    pc_op_e op;
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (ld)   op = OP_LD;
    else if (br)   op = OP_BR;
    else if (up)   op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_stack_if.sv
// pc_stack_if: command/address bundle between the control unit and pc_stack.
//   master : control unit side; drives Up, Ld, Br, Call, Ret, LdAddr, Offset;
//            observes Addr, Full, Empty (and Err).
//   slave  : pc_stack side; the reverse directions.
// Optional macro PC_ERR_EN adds the sticky Err flag to the bundle.
interface pc_stack_if #(
  parameter int W    = 7,
  parameter int OFFW = 5
);
  logic            Up;
  logic            Ld;
  logic            Br;
  logic            Call;
  logic            Ret;
  logic [W-1:0]    LdAddr;
  logic [OFFW-1:0] Offset;
  logic [W-1:0]    Addr;
  logic            Full;
  logic            Empty;
`ifdef PC_ERR_EN
  logic            Err;

  modport master (
    output Up, Ld, Br, Call, Ret, LdAddr, Offset,
    input  Addr, Full, Empty, Err
  );

  modport slave (
    input  Up, Ld, Br, Call, Ret, LdAddr, Offset,
    output Addr, Full, Empty, Err
  );
`else
  modport master (
    output Up, Ld, Br, Call, Ret, LdAddr, Offset,
    input  Addr, Full, Empty
  );

  modport slave (
    input  Up, Ld, Br, Call, Ret, LdAddr, Offset,
    output Addr, Full, Empty
  );
`endif
endinterface

// File: rtl/ret_stack.sv
// ret_stack: small LIFO holding return addresses.
//   Clk, Clr : clock, synchronous active-high clear (empties the stack)
//   Push     : write DIn at the top (ignored when Full)
//   Pop      : drop the top entry (ignored when Empty)
//   DIn      : value to push
//   DOut     : current top entry, combinational from the array ('0 when empty)
//   Full     : registered, stack holds DEPTH entries
//   Empty    : registered, stack holds no entries
// Entries are not cleared; only the pointer is, so contents are don't-care
// after Clr.
module ret_stack #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Clr,
  input  logic         Push,
  input  logic         Pop,
  input  logic [W-1:0] DIn,
  output logic [W-1:0] DOut,
  output logic         Full,
  output logic         Empty
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [W-1:0]   mem [DEPTH];
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_d;
  logic [SPW-1:0] top_idx;
  logic           do_push;
  logic           do_pop;

  assign do_push = Push && !Full;
  assign do_pop  = Pop && !Empty;
  assign top_idx = sp_q - 1'b1;

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + 1'b1;
    else if (do_pop) sp_d = sp_q - 1'b1;
  end

  // Loop compares keep every array index in range even though the pointer
  // can encode values past DEPTH-1.
  always_comb begin
    DOut = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!Empty && top_idx == SPW'(i)) DOut = mem[i];
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      sp_q  <= '0;
      Full  <= 1'b0;
      Empty <= 1'b1;
    end else begin
      sp_q  <= sp_d;
      Full  <= (sp_d == SPW'(DEPTH));
      Empty <= (sp_d == '0);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr && do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sp_q == SPW'(i)) mem[i] <= DIn;
      end
    end
  end

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with increment, absolute load, signed relative
// branch and call/return through an internal return-address stack.
//   Clk  : clock, rising edge
//   Clr  : synchronous active-high reset (Addr=0, stack emptied, Err=0)
//   bus  : pc_stack_if slave modport
//          in : Up, Ld, Br, Call, Ret, LdAddr[W-1:0], Offset[OFFW-1:0]
//          out: Addr[W-1:0] (registered), Full, Empty, Err (PC_ERR_EN only)
// Optional macro PC_ERR_EN: Call-when-Full and Ret-when-Empty leave Addr
// untouched and set the sticky Err flag; without it a Call on a full stack
// still jumps (push dropped) and a Ret on an empty stack holds.
module pc_stack
  import pc_pkg::*;
#(
  parameter int W     = PC_W,
  parameter int DEPTH = PC_DEPTH,
  parameter int OFFW  = PC_OFFW
) (
  input  logic   Clk,
  input  logic   Clr,
  pc_stack_if.slave bus
);

  pc_op_e       op;
  logic [W-1:0] addr_q;
  logic [W-1:0] addr_d;
  logic [W-1:0] ret_addr;
  logic [W-1:0] top;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;

  assign op       = pc_decode(bus.Ret, bus.Call, bus.Ld, bus.Br, bus.Up);
  assign ret_addr = addr_q + 1'b1;

  ret_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_stack (
    .Clk   (Clk),
    .Clr   (Clr),
    .Push  (push),
    .Pop   (pop),
    .DIn   (ret_addr),
    .DOut  (top),
    .Full  (full),
    .Empty (empty)
  );

`ifdef PC_ERR_EN
  logic err_q;
  logic err_set;

  always_comb begin
    addr_d  = addr_q;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    unique case (op)
      OP_INC: addr_d = addr_q + 1'b1;
      // Size cast of a signed operand sign-extends Offset to W bits.
      OP_BR:  addr_d = addr_q + W'($signed(bus.Offset));
      OP_LD:  addr_d = bus.LdAddr;
      OP_CALL: begin
        if (full) begin
          err_set = 1'b1;
        end else begin
          push   = 1'b1;
          addr_d = bus.LdAddr;
        end
      end
      OP_RET: begin
        if (empty) begin
          err_set = 1'b1;
        end else begin
          pop    = 1'b1;
          addr_d = top;
        end
      end
      default: addr_d = addr_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign bus.Err = err_q;
`else
  always_comb begin
    addr_d = addr_q;
    push   = 1'b0;
    pop    = 1'b0;
    unique case (op)
      OP_INC: addr_d = addr_q + 1'b1;
      OP_BR:  addr_d = addr_q + W'($signed(bus.Offset));
      OP_LD:  addr_d = bus.LdAddr;
      OP_CALL: begin
        // The stack drops a push when full; the jump happens regardless.
        push   = 1'b1;
        addr_d = bus.LdAddr;
      end
      OP_RET: begin
        if (!empty) begin
          pop    = 1'b1;
          addr_d = top;
        end
      end
      default: addr_d = addr_q;
    endcase
  end
`endif

  always_ff @(posedge Clk) begin
    if (Clr) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign bus.Addr  = addr_q;
  assign bus.Full  = full;
  assign bus.Empty = empty;

endmodule
